// File: rtl/mod_reduce_seq.sv
//------------------------------------------------------------------------------
// mod_reduce_seq
//
// Sequential residue reducer: accepts an IN_W-bit unsigned operand and returns
// operand mod MOD. The operand is consumed CHUNK_W bits per clock, starting at
// the least significant chunk. Each chunk value is mapped to its weighted
// residue (v * 2^(CHUNK_W*i)) mod MOD through a constant table that is built
// at elaboration time. The weighted residues are summed in a modular
// accumulator. Because both addends are below MOD, one conditional subtract
// keeps the accumulator reduced.
//
// Parameters:
//    IN_W     operand width in bits (>= 1)
//    the modulus parameter MOD must be >= 2
//    OUT_W    residue width, 2^OUT_W >= MOD
//    CHUNK_W  bits consumed per cycle (1..8)
//
// Ports:
//    clk        in   sole clock, rising edge
//    rst        in   asynchronous, active-high reset
//    in_valid   in   operand offered
//    in_ready   out  block can accept an operand (registered, IDLE only)
//    in_data    in   IN_W-bit unsigned operand
//    out_valid  out  residue available (registered, DONE only)
//    out_ready  in   consumer accepts the residue
//    out_res    out  in_data mod MOD; holds its value until the next result
//    busy       out  high in RUN or DONE
//    out_zero   out  residue is zero while out_valid (present only with the
//                    optional zero-flag macro)
//
// Optional feature macro: MODRED_ZERO_FLAG_EN
//
// Timing: out_valid rises NCHUNK rising edges after the accept edge. One
// operand completes every NCHUNK+2 cycles at best, because the hand-off edge
// and the next accept edge cannot coincide.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand
// RUN   | folding one chunk per cycle into the accumulator
// DONE  | out_valid high, residue held until out_ready
//------------------------------------------------------------------------------
module mod_reduce_seq #(
   parameter int IN_W    = 18,
   parameter int MOD     = 503,
   parameter int OUT_W   = 9,
   parameter int CHUNK_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_res,
   output logic             busy
`ifdef MODRED_ZERO_FLAG_EN
   ,
   output logic             out_zero
`endif
);

   localparam int NCHUNK = (IN_W + CHUNK_W - 1) / CHUNK_W;
   localparam int PAD_W  = NCHUNK * CHUNK_W;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int NVAL   = 1 << CHUNK_W;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);
   localparam logic [OUT_W:0]   MOD_W    = (OUT_W + 1)'(MOD);

   //---------------------------------------------------------------------------
   // Parameter sanity: stop elaboration on an unusable configuration.
   //---------------------------------------------------------------------------
   if (MOD < 2) begin : g_bad_mod
      $error("mod_reduce_seq: MOD must be >= 2");
   end
   if ((64'd1 << OUT_W) < 64'(MOD)) begin : g_bad_out_w
      $error("mod_reduce_seq: 2^OUT_W must be >= MOD");
   end
   if (CHUNK_W < 1 || CHUNK_W > 8) begin : g_bad_chunk
      $error("mod_reduce_seq: CHUNK_W must be in 1..8");
   end
   if (IN_W < 1) begin : g_bad_in_w
      $error("mod_reduce_seq: IN_W must be >= 1");
   end

   //---------------------------------------------------------------------------
   // Weighted residue table, folded to constants at elaboration.
   // The chunk weight 2^(CHUNK_W*i) is reduced by repeated doubling mod MOD,
   // so intermediate values stay below 2*MOD and fit comfortably in longint.
   //---------------------------------------------------------------------------
   function automatic logic [OUT_W-1:0] tbl_entry(input int chunk_i, input int chunk_v);
      longint pow_m;
      longint prod;
      pow_m = 64'd1 % longint'(MOD);
      for (int k = 0; k < CHUNK_W * chunk_i; k++) begin
         pow_m = (pow_m * 2) % longint'(MOD);
      end
      prod = (longint'(chunk_v) * pow_m) % longint'(MOD);
      return OUT_W'(prod);
   endfunction

   logic [OUT_W-1:0] tbl [NCHUNK][NVAL];

   for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_tbl_row
      for (genvar gv = 0; gv < NVAL; gv++) begin : g_tbl_col
         assign tbl[gi][gv] = tbl_entry(gi, gv);
      end
   end

   //---------------------------------------------------------------------------
   // State and datapath registers
   //---------------------------------------------------------------------------
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_next;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [OUT_W-1:0] out_res_q;
   logic [OUT_W-1:0] acc_q;
   logic [IDX_W-1:0] idx_q;
   logic [PAD_W-1:0] data_q;

   logic               accept;
   logic               is_last;
   logic [CHUNK_W-1:0] chunk;
   logic [OUT_W-1:0]   tbl_val;
   logic [OUT_W:0]     sum_c;
   logic [OUT_W-1:0]   acc_next;

   // in_ready_q is only ever high in IDLE, so the state term is redundant but
   // keeps the accept condition self-evidently tied to the FSM.
   assign accept  = in_valid && in_ready_q && (state_q == S_IDLE);
   assign is_last = (idx_q == LAST_IDX);

   // data_q shifts right each RUN cycle, so the current chunk is always at
   // the bottom and idx_q only selects the table row.
   assign chunk   = data_q[CHUNK_W-1:0];
   assign tbl_val = tbl[idx_q][chunk];

   always_comb begin
      sum_c    = {1'b0, acc_q} + {1'b0, tbl_val};
      acc_next = acc_q;
      if (sum_c >= MOD_W) begin
         acc_next = OUT_W'(sum_c - MOD_W);
      end else begin
         acc_next = OUT_W'(sum_c);
      end
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_next = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (is_last) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // State register and datapath.
   // in_ready and out_valid are registered from the next state so that both
   // read 0 throughout reset and in_ready only rises on the first edge after
   // reset is released.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_res_q   <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         data_q      <= '0;
      end else begin
         state_q     <= state_next;
         in_ready_q  <= (state_next == S_IDLE);
         out_valid_q <= (state_next == S_DONE);
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  data_q <= PAD_W'(in_data);
                  acc_q  <= '0;
                  idx_q  <= '0;
               end
            end
            S_RUN: begin
               acc_q  <= acc_next;
               data_q <= data_q >> CHUNK_W;
               if (is_last) begin
                  idx_q     <= '0;
                  out_res_q <= acc_next;
               end else begin
                  idx_q <= idx_q + IDX_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef MODRED_ZERO_FLAG_EN
   logic out_zero_q;

   // Tracks the result being presented: taken from the final accumulator on
   // the RUN-to-DONE edge, held from out_res_q while DONE persists, and
   // cleared whenever the FSM is not heading into DONE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_zero_q <= 1'b0;
      end else if (state_next == S_DONE) begin
         if (state_q == S_RUN) begin
            out_zero_q <= (acc_next == '0);
         end else begin
            out_zero_q <= (out_res_q == '0);
         end
      end else begin
         out_zero_q <= 1'b0;
      end
   end

   assign out_zero = out_zero_q;
`endif

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_res   = out_res_q;
   assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mod_reduce_seq.sv
//------------------------------------------------------------------------------
// tb_mod_reduce_seq
//
// Self-checking bench for mod_reduce_seq. Two instances: the default
// configuration (18-bit operand, mod 503, 2-bit chunks) and a partial top
// chunk configuration (8-bit operand, mod 7, 3-bit chunks). Expected residues
// come from plain '%' arithmetic or constants.
//------------------------------------------------------------------------------
module tb_mod_reduce_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // default instance
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [17:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [8:0]  out_res;
   logic        busy;
`ifdef MODRED_ZERO_FLAG_EN
   logic        out_zero;
`endif

   // small instance
   logic        c_in_valid = 1'b0;
   logic        c_in_ready;
   logic [7:0]  c_in_data = '0;
   logic        c_out_valid;
   logic        c_out_ready = 1'b0;
   logic [2:0]  c_out_res;
   logic        c_busy;
`ifdef MODRED_ZERO_FLAG_EN
   logic        c_out_zero;
`endif

   mod_reduce_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .busy      (busy)
`ifdef MODRED_ZERO_FLAG_EN
      ,
      .out_zero  (out_zero)
`endif
   );

   mod_reduce_seq #(.IN_W(8), .MOD(7), .OUT_W(3), .CHUNK_W(3)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (c_in_valid),
      .in_ready  (c_in_ready),
      .in_data   (c_in_data),
      .out_valid (c_out_valid),
      .out_ready (c_out_ready),
      .out_res   (c_out_res),
      .busy      (c_busy)
`ifdef MODRED_ZERO_FLAG_EN
      ,
      .out_zero  (c_out_zero)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Offer one operand to the default instance, check latency/result, hold
   // the result for bp cycles of backpressure, then hand it off.
   task automatic send(input int op, input int exp, input int bp);
      int guard;
      int lat;
      guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check("in_ready_before_accept", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = 18'(op);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 18'($urandom);
      check("busy_after_accept", 32'(busy), 32'd1);
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("latency", 32'(lat), 32'd9);
      check("out_res", 32'(out_res), 32'(exp));
`ifdef MODRED_ZERO_FLAG_EN
      check("out_zero", 32'(out_zero), 32'(exp == 0));
`endif
      for (int i = 0; i < bp; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_res", 32'(out_res), 32'(exp));
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("valid_drop", 32'(out_valid), 32'd0);
      check("in_ready_after_handoff", 32'(in_ready), 32'd1);
      check("res_held_idle", 32'(out_res), 32'(exp));
   endtask

   task automatic send2(input int op, input int exp);
      int guard;
      int lat;
      guard = 0;
      while (!c_in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      c_in_valid = 1'b1;
      c_in_data  = 8'(op);
      @(posedge clk);
      @(negedge clk);
      c_in_valid = 1'b0;
      c_in_data  = 8'($urandom);
      lat = 0;
      while (!c_out_valid && lat < 40) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check("c_latency", 32'(lat), 32'd3);
      check("c_out_res", 32'(c_out_res), 32'(exp));
`ifdef MODRED_ZERO_FLAG_EN
      check("c_out_zero", 32'(c_out_zero), 32'(exp == 0));
`endif
      c_out_ready = 1'b1;
      @(negedge clk);
      c_out_ready = 1'b0;
      check("c_valid_drop", 32'(c_out_valid), 32'd0);
   endtask

   typedef struct {
      int op;
      int res;
      int bp;
   } vec_t;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      vec_t vecs[6];
      int   b2b_ops[2];
      int   got[$];
      int   sent;
      int   op;
      bit   saw_valid;
      bit   acc_now;
      bit   take_now;
      logic [8:0] res_now;

      vecs = '{
         '{0,      0,   0},
         '{503,    0,   0},
         '{262143, 80,  0},
         '{1000,   497, 5},
         '{502,    502, 0},
         '{504,    1,   2}
      };

      // reset state
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_res", 32'(out_res), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
`ifdef MODRED_ZERO_FLAG_EN
      check("rst_out_zero", 32'(out_zero), 32'd0);
`endif
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("in_ready_before_first_edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("in_ready_after_first_edge", 32'(in_ready), 32'd1);

      // table-driven vectors
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].op, vecs[i].res, vecs[i].bp);
      end

      // reset during the 4th RUN cycle of 12345
      in_valid = 1'b1;
      in_data  = 18'd12345;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_out_res", 32'(out_res), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_valid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      check("midrst_no_valid", 32'(saw_valid), 32'd0);
      send(12345, 273, 0);

      // back-to-back with in_valid held high
      b2b_ops  = '{502, 504};
      sent     = 0;
      in_valid = 1'b1;
      in_data  = 18'(b2b_ops[0]);
      out_ready = 1'b1;
      for (int cyc = 0; cyc < 60; cyc++) begin
         acc_now  = in_valid && in_ready;
         take_now = out_valid && out_ready;
         res_now  = out_res;
         @(negedge clk);
         if (take_now) got.push_back(int'(res_now));
         if (acc_now) begin
            sent++;
            if (sent < 2) in_data = 18'(b2b_ops[sent]);
            else in_valid = 1'b0;
         end
      end
      out_ready = 1'b0;
      check("b2b_sent", 32'(sent), 32'd2);
      check("b2b_count", 32'(got.size()), 32'd2);
      if (got.size() == 2) begin
         check("b2b_first", 32'(got[0]), 32'd502);
         check("b2b_second", 32'(got[1]), 32'd1);
      end

      // randomized operands against a plain modulo model
      for (int i = 0; i < 20; i++) begin
         op = int'($urandom_range(0, 262143));
         send(op, op % 503, int'($urandom_range(0, 3)));
      end

      // partial top chunk instance
      send2(255, 3);
      send2(7, 0);
      send2(100, 2);
      for (int i = 0; i < 8; i++) begin
         op = int'($urandom_range(0, 255));
         send2(op, op % 7);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mod_reduce_seq.md
Name: mod_reduce_seq

Overview:
- Parametrised, sequential residue reducer: accepts an IN_W-bit unsigned operand and returns operand mod MOD.
- Generalises our fixed 2-input-bit residue LUT slices (mod 503, 9-bit output) to any width, modulus and chunk size.
- Processes one CHUNK_W-bit slice per clock through an elaboration-time residue table and a modular accumulator.
- Sits between the operand bus and the RNS channel logic, with valid/ready on both sides.

Parameters:
- IN_W, 18, operand width in bits (>= 1).
- MOD, 503, modulus (>= 2).
- OUT_W, 9, residue width; must satisfy 2^OUT_W >= MOD, otherwise elaboration error.
- CHUNK_W, 2, bits consumed per cycle (1..8).
- Derived localparam NCHUNK = ceil(IN_W / CHUNK_W).

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand offered.
- in_ready  output  1  block can accept an operand.
- in_data  input  IN_W  unsigned operand.
- out_valid  output  1  residue available.
- out_ready  input  1  consumer accepts the residue.
- out_res  output  OUT_W  in_data mod MOD, always < MOD.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset: asynchronous clear while rst=1. in_ready=0, out_valid=0, out_res=0, busy=0, accumulator=0, chunk index=0, FSM=IDLE. in_ready rises on the first clock edge after rst deasserts (IDLE drives in_ready=1).
- Tables: T[i][v] = (v * 2^(CHUNK_W*i)) mod MOD for i in 0..NCHUNK-1 and v in 0..2^CHUNK_W-1. Computed by a constant function at elaboration; no runtime multiply.
- FSM IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture in_data (zero-extended to NCHUNK*CHUNK_W), acc <= 0, idx <= 0, go to RUN.
- FSM RUN:
  - in_ready=0.
  - Each cycle: s = acc + T[idx][chunk idx]; acc <= (s >= MOD) ? s - MOD : s. Both terms are < MOD, so one conditional subtract suffices; adder is OUT_W+1 bits.
  - idx increments each cycle.
  - After processing idx = NCHUNK-1, go to DONE.
- FSM DONE:
  - out_valid=1 and out_res=acc, held stable until out_ready.
  - On out_ready: go to IDLE, out_valid drops the next cycle.
  - An operand cannot be accepted in the same cycle as the hand-off (no bypass).
- Latency: out_valid asserts exactly NCHUNK rising edges after the accept edge. Throughput is one operand per NCHUNK+2 cycles.
- Top chunk: if IN_W is not a multiple of CHUNK_W, the top chunk is zero-extended.
- Stability: out_res only changes on the RUN-to-DONE transition; it holds its last value in IDLE.
- Reset mid-operation: an operation in RUN or DONE is discarded immediately; no output handshake occurs.
- X-safety: in_data is ignored unless accepted.

Optional Feature:
- MODRED_ZERO_FLAG_EN defined:
  - Adds output port out_zero (1 bit), registered alongside out_res.
  - High while out_valid=1 and the residue is 0 (operand divisible by MOD); 0 otherwise and in reset.
- Not defined: port and logic absent; all other behaviour identical.

Test Plan:
- Defaults; send 0, then 503 -> out_res=0 both times; out_valid rises 9 edges after each accept (out_zero=1 if enabled).
- Defaults; send 262143 (all ones) -> out_res=80; send 1000 -> out_res=497; out_zero=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_res stable and in_ready=0 throughout; single hand-off when out_ready=1, in_ready=1 on the following cycle.
- Reset at the 4th RUN cycle of operand 12345 -> all outputs 0 immediately, no out_valid. Next operand 12345 -> out_res=273.
- IN_W=8, MOD=7, OUT_W=3, CHUNK_W=3 (partial top chunk) -> 255 gives 3; 7 gives 0; 100 gives 2; latency 3 edges.
- Back-to-back: in_valid held high with operands 502, 504 and out_ready=1 -> residues 502 then 1, in order, with no operand dropped or duplicated.
